// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined add/sub/accumulate unit with a carry chain split
// into STAGES register slices, valid/ready handshakes and signed saturation.
// Ports: clk, rst (async active-low); in_valid/in_ready, a, b, op, sat
// (request); out_valid/out_ready, sum, cout, ovf (result).
// op: 00 a+b, 01 a-b, 10 acc+a, 11 clear acc (result 0).
module addsub_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SW = WIDTH / STAGES;
    localparam int L  = STAGES - 1;

    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    // x/y carry the operands still to be summed; r collects finished
    // slices; c is the carry into the next slice (cout in final stage).
    typedef struct packed {
        logic             vld;
        logic [1:0]       op;
        logic             sat;
        logic             c;
        logic             ovf;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] r;
    } stg_t;

    stg_t             q [STAGES];
    stg_t             d [STAGES];
    stg_t             s0;
    stg_t             cur;
    logic [SW:0]      t;
    logic             xm;
    logic             ym;
    logic [WIDTH-1:0] acc;
    logic             stall;
    logic             acc_pending;

    always_comb stall = q[L].vld & ~out_ready;

    // An acc op must reach the final stage (and update acc) before the
    // next request may read acc, so any acc op in flight blocks input.
    always_comb begin
        acc_pending = 1'b0;
        for (int k = 0; k < L; k++)
            acc_pending = acc_pending | (q[k].vld & q[k].op[1]);
    end

    always_comb in_ready = ~stall & ~acc_pending;

    // Operand formation; op 11 is 0 + 0 so sum, cout and ovf are all 0.
    always_comb begin
        s0     = '0;
        s0.vld = in_valid & in_ready;
        s0.op  = op;
        s0.sat = sat;
        unique case (op)
            2'b00: begin
                s0.x = a;
                s0.y = b;
            end
            2'b01: begin
                s0.x = a;
                s0.y = ~b;
                s0.c = 1'b1;
            end
            2'b10: begin
                s0.x = acc;
                s0.y = a;
            end
            default: ;
        endcase
    end

    // Stage k adds slice k of its source; stage 0 sources the request.
    always_comb begin
        cur = '0;
        t   = '0;
        xm  = 1'b0;
        ym  = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            cur = (k == 0) ? s0 : q[(k == 0) ? 0 : k - 1];
            t = {1'b0, cur.x[k*SW +: SW]}
              + {1'b0, cur.y[k*SW +: SW]}
              + {{SW{1'b0}}, cur.c};
            cur.r[k*SW +: SW] = t[SW-1:0];
            cur.c = t[SW];
            d[k] = cur;
        end
        // Same-sign operands with a differently signed result is
        // exactly carry-into-MSB xor carry-out-of-MSB.
        xm = d[L].x[WIDTH-1];
        ym = d[L].y[WIDTH-1];
        d[L].ovf = (xm == ym) & (d[L].r[WIDTH-1] != xm);
        // On overflow the true sign is the operands' common sign.
        if (d[L].sat & d[L].ovf)
            d[L].r = xm ? SMIN : SMAX;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < STAGES; k++)
                q[k] <= '0;
            acc <= '0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++)
                q[k] <= d[k];
            if (d[L].vld && d[L].op[1])
                acc <= d[L].r;
        end
    end

    assign out_valid = q[L].vld;
    assign sum       = q[L].r;
    assign cout      = q[L].c;
    assign ovf       = q[L].ovf;

endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: vector table plus scoreboard bench for addsub_pipe
// (WIDTH=16, STAGES=2).
module tb_addsub_pipe;

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        sat;
        logic [15:0] es;
        logic        ec;
        logic        eo;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [1:0]  op = '0;
    logic        sat = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int   total = 0;
    int   bad = 0;
    exp_t sbq[$];
    exp_t mon_e;
    logic [15:0] macc = '0;
    vec_t tv[12];
    bit   done;

    addsub_pipe #(.WIDTH(16), .STAGES(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .sat(sat),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got %h want none",
                         {sum, cout, ovf});
            end else begin
                mon_e = sbq.pop_front();
                chk("result", {14'd0, sum, cout, ovf}, {14'd0, mon_e});
            end
        end
    end

    task automatic model(input logic [1:0] o, input logic [15:0] aa,
                         input logic [15:0] bb, input logic s,
                         output exp_t e);
        int tr;
        logic [16:0] u;
        case (o)
            2'b00: begin
                tr = int'($signed(aa)) + int'($signed(bb));
                u = {1'b0, aa} + {1'b0, bb};
            end
            2'b01: begin
                tr = int'($signed(aa)) - int'($signed(bb));
                u = {(aa >= bb), 16'(aa - bb)};
            end
            2'b10: begin
                tr = int'($signed(macc)) + int'($signed(aa));
                u = {1'b0, macc} + {1'b0, aa};
            end
            default: begin
                tr = 0;
                u = '0;
            end
        endcase
        e.o = (tr > 32767) || (tr < -32768);
        e.c = u[16];
        e.s = (s && e.o) ? ((tr > 0) ? 16'h7FFF : 16'h8000) : u[15:0];
        if (o == 2'b10) macc = e.s;
        else if (o == 2'b11) macc = '0;
    endtask

    task automatic send(input logic [1:0] o, input logic [15:0] aa,
                        input logic [15:0] bb, input logic s,
                        input exp_t e, output int w);
        in_valid = 1'b1;
        op = o;
        a = aa;
        b = bb;
        sat = s;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!in_ready && w < 200);
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready 0 want 1");
        end else begin
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sbq.size(), 0);
    endtask

    initial begin
        int w;
        exp_t e;

        tv[0]  = '{2'b00, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tv[1]  = '{2'b00, 16'h7FFF, 16'h0001, 1'b1, 16'h7FFF, 1'b0, 1'b1};
        tv[2]  = '{2'b00, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tv[3]  = '{2'b01, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        tv[4]  = '{2'b01, 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1};
        tv[5]  = '{2'b00, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
        tv[6]  = '{2'b01, 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1, 1'b0};
        tv[7]  = '{2'b00, 16'h8000, 16'h8000, 1'b1, 16'h8000, 1'b1, 1'b1};
        tv[8]  = '{2'b00, 16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        tv[9]  = '{2'b01, 16'h7FFF, 16'hFFFF, 1'b1, 16'h7FFF, 1'b0, 1'b1};
        tv[10] = '{2'b00, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        tv[11] = '{2'b01, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};

        // reset state, asynchronous
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_flags", {cout, ovf}, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("in_ready_after_rst", in_ready, 1);

        // exact latency of two cycles
        @(posedge clk);
        #1;
        send(2'b00, 16'h0010, 16'h0020, 1'b0, '{16'h0030, 1'b0, 1'b0}, w);
        @(negedge clk);
        chk("latency_1", out_valid, 0);
        @(negedge clk);
        chk("latency_2", out_valid, 1);
        drain();

        // table, back to back
        @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++) begin
            send(tv[i].op, tv[i].a, tv[i].b, tv[i].sat,
                 '{tv[i].es, tv[i].ec, tv[i].eo}, w);
            chk("table_wait", w, 1);
        end
        drain();

        // back-to-back adds with a 3-cycle output stall
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 1; i <= 4; i++)
                    send(2'b00, 16'(i), 16'(i), 1'b0,
                         '{16'(2 * i), 1'b0, 1'b0}, w);
            end
            begin
                int n = 0;
                do begin
                    @(posedge clk);
                    #1;
                    n++;
                end while (!out_valid && n < 50);
                chk("stall_start", out_valid, 1);
                out_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_hold_sum", sum, 16'h0002);
                    chk("stall_hold_valid", out_valid, 1);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // accumulator sequence
        @(posedge clk);
        #1;
        send(2'b11, 16'h1234, 16'h5678, 1'b0, '{16'h0000, 1'b0, 1'b0}, w);
        send(2'b10, 16'h0003, 16'hFFFF, 1'b0, '{16'h0003, 1'b0, 1'b0}, w);
        chk("acc_block_1", w, 2);
        send(2'b10, 16'h0004, 16'h0000, 1'b0, '{16'h0007, 1'b0, 1'b0}, w);
        chk("acc_block_2", w, 2);
        send(2'b10, 16'h0000, 16'h0000, 1'b0, '{16'h0007, 1'b0, 1'b0}, w);
        chk("acc_block_3", w, 2);
        macc = 16'h0007;
        drain();

        // reset with ops in flight
        @(posedge clk);
        #1;
        send(2'b10, 16'h0055, 16'h0000, 1'b0, '{16'h005C, 1'b0, 1'b0}, w);
        send(2'b00, 16'h1234, 16'h0001, 1'b0, '{16'h1235, 1'b0, 1'b0}, w);
        send(2'b00, 16'h0100, 16'h0200, 1'b0, '{16'h0300, 1'b0, 1'b0}, w);
        chk("pre_rst_valid", out_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_valid", out_valid, 0);
        chk("rst_async_sum", sum, 0);
        sbq.delete();
        macc = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("in_ready_after_rst2", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_stale", out_valid, 0);
        end
        @(posedge clk);
        #1;
        send(2'b10, 16'h0000, 16'h0000, 1'b0, '{16'h0000, 1'b0, 1'b0}, w);
        drain();

        // random ops with random backpressure
        @(posedge clk);
        #1;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [1:0]  ro;
                    logic [15:0] ra;
                    logic [15:0] rb;
                    logic        rs;
                    ro = 2'($urandom_range(0, 3));
                    ra = 16'($urandom);
                    rb = 16'($urandom);
                    rs = 1'($urandom_range(0, 1));
                    model(ro, ra, rb, rs, e);
                    send(ro, ra, rb, rs, e, w);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/addsub_pipe.md
ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits (>=4).
REQ-002 SHALL have parameter STAGES, default 2, number of register stages in the carry chain (1..4); WIDTH SHALL be divisible by STAGES.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operation request present.
REQ-006 SHALL have port in_ready  output  1  block accepts the request this cycle.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B (ignored for accumulator ops).
REQ-009 SHALL have port op  input  2  00 add, 01 sub, 10 accumulate (acc+a), 11 accumulator clear.
REQ-010 SHALL have port sat  input  1  per-operation signed saturation enable.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-013 SHALL have port sum  output  WIDTH  result.
REQ-014 SHALL have port cout  output  1  carry out of MSB (sub: 1 = no borrow).
REQ-015 SHALL have port ovf  output  1  two's-complement signed overflow of the unsaturated result.

Function
REQ-016 Transfer SHALL occur on an edge where in_valid & in_ready; result retires on an edge where out_valid & out_ready.
REQ-017 Sub SHALL compute a + ~b + 1 (carry-in 1); add carry-in 0; accumulate SHALL compute acc + a, carry-in 0.
REQ-018 Carry chain SHALL be split into STAGES slices of WIDTH/STAGES bits; slice k computed in stage k, its carry registered into stage k+1 with the pending upper operand bits.
REQ-019 Latency SHALL be exactly STAGES cycles from accepting edge to out_valid=1 when unstalled; throughput one op/cycle for add/sub.
REQ-020 Final stage register SHALL drive sum, cout, ovf, out_valid; these SHALL hold stable while out_valid & ~out_ready.
REQ-021 Stall = out_valid & ~out_ready; when stalled every stage SHALL hold; bubbles are not collapsed.
REQ-022 in_ready SHALL be ~stall & ~acc_pending, where acc_pending = an op 10/11 valid in any non-final stage; in_ready SHALL not depend on op, a, b.
REQ-023 Accumulator register acc (WIDTH) SHALL load the op-10 result, or 0 for op 11, on the edge that result enters the final stage.
REQ-024 Op 11 SHALL produce sum=0, cout=0, ovf=0.
REQ-025 ovf SHALL be carry-into-MSB XOR carry-out-of-MSB for the unsaturated result.
REQ-026 With sat=1 and ovf=1, sum (and acc for op 10) SHALL be the signed max 0111..1 if the true result is positive, else signed min 100..0; cout and ovf still report the unsaturated values.
REQ-027 Unsigned wrap-around (sat=0) SHALL be modulo 2^WIDTH with no other side effect.
REQ-028 Ops SHALL retire in acceptance order; none SHALL be dropped or duplicated under any out_ready pattern.
REQ-029 With STAGES=1 acc_pending SHALL be constant 0 and latency 1 cycle.

Reset
REQ-030 While rst=0, all stage valid bits, out_valid, sum, cout, ovf, acc SHALL be 0 asynchronously; in-flight ops SHALL be discarded.
REQ-031 in_ready SHALL be 1 in the first cycle after rst deasserts (out_valid=0, no acc op pending).

Verification (WIDTH=16, STAGES=2, out_ready=1 unless stated)
REQ-032 add 0x7FFF+0x0001 sat=0 -> sum 0x8000, ovf 1, cout 0 after 2 cycles; same with sat=1 -> sum 0x7FFF, ovf 1.
REQ-033 add 0xFFFF+0x0001 -> sum 0x0000, cout 1, ovf 0; sub 0x0005-0x0007 -> sum 0xFFFE, cout 0, ovf 0; sub 0x8000-0x0001 sat=1 -> 0x8000, ovf 1.
REQ-034 Back-to-back 4 adds, out_ready low 3 cycles after first result -> in_ready 0 during stall, sum held, all 4 results in order, none lost.
REQ-035 op 11, op 10 a=3, op 10 a=4 -> sum 0, 3, 7; in_ready 0 for one cycle after each accepted op; acc=7 at end.
REQ-036 rst low while two ops in flight and out_valid=1 -> out_valid, sum, acc go 0 without clock edge; no stale result after release.
